// File: rtl/k_fft_pkg.sv
// Shared definitions for the radix-4 DIF FFT sequencer.
//  - Default transform size (LOG4N / N / ADDR_W).
//  - FSM state encoding of the butterfly sequencer.
//  - Butterfly address helpers (read address of leg m, twiddle exponent),
//    written with shifts and masks only so they stay cheap in hardware.
package k_fft_pkg;

  localparam int LOG4N  = 3;
  localparam int N      = 4 ** LOG4N;
  localparam int ADDR_W = 2 * LOG4N;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } fsm_state_e;

  // Read address of leg m (0..3) of butterfly b in stage s.
  // span = 4**(log4n-1-s); g = b/span; k = b%span; addr = 4*span*g + k + m*span.
  function automatic int bfly_rd_addr(int log4n, int s, int b, int m);
    int sh;
    int g;
    int k;
    sh = 2 * (log4n - 1 - s);
    g  = b >> sh;
    k  = b & ((1 << sh) - 1);
    return (g << (sh + 2)) + k + (m << sh);
  endfunction

  // Twiddle exponent for butterfly b in stage s: k * 4**s.
  function automatic int bfly_tw_idx(int log4n, int s, int b);
    int sh;
    int k;
    sh = 2 * (log4n - 1 - s);
    k  = b & ((1 << sh) - 1);
    return k << (2 * s);
  endfunction

endpackage

// File: rtl/k_dly_line.sv
// Stall-enabled shift register: dout is din delayed by DEPTH enabled cycles.
// Ports:
//  clk, rst_n  clock, asynchronous active-low reset (clears every tap)
//  en          1 = shift one position; 0 = hold all taps
//  din         WIDTH-bit input
//  dout        WIDTH-bit output of the last tap
module k_dly_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] taps [DEPTH];

  // NOTE: every tap is reset, not just the valid bit, so a reset mid-transform
  // leaves no stale write address behind and the outputs read exactly 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else if (en) begin
      taps[0] <= din;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign dout = taps[DEPTH-1];

endmodule

// File: rtl/k_dragonfly_seq.sv
// Sequencer for a radix-4 float dragonfly in an in-place N-point DIF FFT.
// Per stage it issues one butterfly per cycle (four read addresses, twiddle
// exponent, scaling code), then drains the dragonfly pipeline before the next
// stage so no stage reads a sample still in flight. Write-back addresses are
// the read addresses delayed PIPE_LAT unstalled cycles.
// Ports:
//  clk, rst_n            clock, asynchronous active-low reset
//  start                 begin a transform (sampled only in IDLE)
//  stall                 freeze all state; rd_en/wr_en forced low
//  scale_cfg             2-bit scaling code per stage, latched on start
//  busy, done            transform in progress / one-cycle completion pulse
//  stage                 current stage index
//  rd_en, rd_addr0..3    butterfly read strobe and addresses
//  tw_idx, scaling       twiddle exponent and scaling code, valid with rd_en
//  wr_en, wr_addr0..3    write-back strobe and addresses
module k_dragonfly_seq
  import k_fft_pkg::*;
#(
  parameter int  LOG4N    = k_fft_pkg::LOG4N,
  parameter int  PIPE_LAT = 2,
  localparam int ADDR_W   = 2 * LOG4N,
  localparam int STAGE_W  = (LOG4N > 1) ? $clog2(LOG4N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic [2*LOG4N-1:0] scale_cfg,
  output logic               busy,
  output logic               done,
  output logic [STAGE_W-1:0] stage,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr0,
  output logic [ADDR_W-1:0]  rd_addr1,
  output logic [ADDR_W-1:0]  rd_addr2,
  output logic [ADDR_W-1:0]  rd_addr3,
  output logic [ADDR_W-1:0]  tw_idx,
  output logic [1:0]         scaling,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr0,
  output logic [ADDR_W-1:0]  wr_addr1,
  output logic [ADDR_W-1:0]  wr_addr2,
  output logic [ADDR_W-1:0]  wr_addr3
);

  localparam int DLY_W = 1 + 4 * ADDR_W;
  localparam logic [ADDR_W-1:0]  B_LAST = ADDR_W'((1 << (2 * (LOG4N - 1))) - 1);
  localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(LOG4N - 1);
  localparam logic [3:0]         D_LAST = 4'(PIPE_LAT - 1);

  fsm_state_e           state_q, state_d;
  logic [ADDR_W-1:0]    b_q, b_d;
  logic [STAGE_W-1:0]   stage_q, stage_d;
  logic [3:0]           dcnt_q, dcnt_d;
  logic [2*LOG4N-1:0]   cfg_q, cfg_d;
  logic                 issue_d;
  logic                 rd_en_q;
  logic                 busy_q;
  logic                 done_q;
  logic [DLY_W-1:0]     dly_out;
  logic                 wr_v;

  // NOTE: all next-state signals get a default first, so no path through the
  // case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    stage_d = stage_q;
    dcnt_d  = dcnt_q;
    cfg_d   = cfg_q;
    unique case (state_q)
      ST_IDLE: begin
        // start is honoured even with stall high: nothing is in flight yet.
        if (start) begin
          state_d = ST_RUN;
          b_d     = '0;
          stage_d = '0;
          dcnt_d  = '0;
          cfg_d   = scale_cfg;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (b_q == B_LAST) state_d = ST_DRAIN;
          else               b_d     = b_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!stall) begin
          if (dcnt_q == D_LAST) begin
            dcnt_d = '0;
            if (stage_q == S_LAST) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
              stage_d = stage_q + 1'b1;
              b_d     = '0;
            end
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      // The done pulse is not held by stall: it always lasts one cycle.
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign issue_d = (state_d == ST_RUN);

  // Outputs are loaded from the next-state values so they are registered yet
  // line up with the cycle the FSM spends in RUN. A stalled RUN cycle recomputes
  // the same b, so the addresses hold.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      b_q      <= '0;
      stage_q  <= '0;
      dcnt_q   <= '0;
      cfg_q    <= '0;
      rd_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_addr0 <= '0;
      rd_addr1 <= '0;
      rd_addr2 <= '0;
      rd_addr3 <= '0;
      tw_idx   <= '0;
      scaling  <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      stage_q <= stage_d;
      dcnt_q  <= dcnt_d;
      cfg_q   <= cfg_d;
      rd_en_q <= issue_d;
      busy_q  <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      done_q  <= (state_d == ST_DONE);
      if (issue_d) begin
        rd_addr0 <= ADDR_W'(bfly_rd_addr(LOG4N, int'(stage_d), int'(b_d), 0));
        rd_addr1 <= ADDR_W'(bfly_rd_addr(LOG4N, int'(stage_d), int'(b_d), 1));
        rd_addr2 <= ADDR_W'(bfly_rd_addr(LOG4N, int'(stage_d), int'(b_d), 2));
        rd_addr3 <= ADDR_W'(bfly_rd_addr(LOG4N, int'(stage_d), int'(b_d), 3));
        tw_idx   <= ADDR_W'(bfly_tw_idx(LOG4N, int'(stage_d), int'(b_d)));
        scaling  <= cfg_d[2*int'(stage_d) +: 2];
      end
    end
  end

  // The delay line carries the ungated issue flag; it only shifts on
  // unstalled cycles, so a stalled RUN cycle is never captured twice.
  k_dly_line #(
    .WIDTH (DLY_W),
    .DEPTH (PIPE_LAT)
  ) u_wr_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~stall),
    .din   ({rd_en_q, rd_addr0, rd_addr1, rd_addr2, rd_addr3}),
    .dout  (dly_out)
  );

  assign {wr_v, wr_addr0, wr_addr1, wr_addr2, wr_addr3} = dly_out;

  assign rd_en = rd_en_q & ~stall;
  assign wr_en = wr_v & ~stall;
  assign busy  = busy_q;
  assign done  = done_q;
  assign stage = stage_q;

endmodule

// File: tb/tb_k_dragonfly_seq.sv
// Self-checking bench for k_dragonfly_seq (LOG4N=3, PIPE_LAT=2).
// The reference works on a timeline of unstalled cycles: butterfly (s,b) is
// issued at unstalled cycle s*(N/4+P)+b+1, written P unstalled cycles later,
// and done falls at LOG4N*(N/4+P)+1. Addresses come from plain division.
module tb_k_dragonfly_seq;

  localparam int LOG4N  = 3;
  localparam int P      = 2;
  localparam int N      = 4 ** LOG4N;
  localparam int NB     = N / 4;
  localparam int AW     = 2 * LOG4N;
  localparam int U_DONE = LOG4N * (NB + P) + 1;
  localparam int LIMIT  = U_DONE + 200;
  localparam int STALL_E = 10;  // stage 0, b = 9

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          stall;
  logic [AW-1:0] scale_cfg;
  logic          busy;
  logic          done;
  logic [1:0]    stage;
  logic          rd_en;
  logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
  logic [AW-1:0] tw_idx;
  logic [1:0]    scaling;
  logic          wr_en;
  logic [AW-1:0] wr_addr0, wr_addr1, wr_addr2, wr_addr3;

  int n_checks;
  int n_errors;

  wire [61:0] all_out = {busy, done, rd_en, wr_en, stage, scaling, tw_idx,
                         rd_addr0, rd_addr1, rd_addr2, rd_addr3,
                         wr_addr0, wr_addr1, wr_addr2, wr_addr3};

  k_dragonfly_seq #(
    .LOG4N    (LOG4N),
    .PIPE_LAT (P)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stall     (stall),
    .scale_cfg (scale_cfg),
    .busy      (busy),
    .done      (done),
    .stage     (stage),
    .rd_en     (rd_en),
    .rd_addr0  (rd_addr0),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .rd_addr3  (rd_addr3),
    .tw_idx    (tw_idx),
    .scaling   (scaling),
    .wr_en     (wr_en),
    .wr_addr0  (wr_addr0),
    .wr_addr1  (wr_addr1),
    .wr_addr2  (wr_addr2),
    .wr_addr3  (wr_addr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit slot(input int e, output int s, output int b);
    int v;
    v = e - 1;
    s = 0;
    b = 0;
    if (v < 0) return 1'b0;
    s = v / (NB + P);
    b = v % (NB + P);
    return (s < LOG4N) && (b < NB);
  endfunction

  function automatic bit in_drain(input int e);
    int v;
    v = e - 1;
    return (e < U_DONE) && ((v % (NB + P)) >= NB);
  endfunction

  function automatic int ref_addr(input int s, input int b, input int m);
    int span;
    span = 4 ** (LOG4N - 1 - s);
    return 4 * span * (b / span) + (b % span) + m * span;
  endfunction

  function automatic int ref_tw(input int s, input int b);
    int span;
    span = 4 ** (LOG4N - 1 - s);
    return (b % span) * (4 ** s);
  endfunction

  // ---------------- transform runner ----------------
  // mode 0: no stall, 1: planned stalls, 2: random stalls.
  // poke: toggle start while busy and hold it high in the DONE cycle.
  // abort_e: assert reset at that unstalled-cycle index (-1 = never).
  // Entered just after a rising edge; leaves just after the edge that ends DONE.
  task automatic run_xform(input int mode, input logic [AW-1:0] cfg, input bit poke,
                           input bit stall0, input int abort_e, input bit spot);
    int  uc, e, cyc, reps, last_e, nstall, done_cyc, s, b, ws, wb, bad;
    bit  st, fin, iss, wiss;
    int  rda [4];
    int  wra [4];
    int  cov [LOG4N][N];
    int  tab [3][4];
    int  tabtw [3];
    tab   = '{'{5, 21, 37, 53}, '{17, 21, 25, 29}, '{20, 21, 22, 23}};
    tabtw = '{5, 4, 0};
    for (int i = 0; i < LOG4N; i++)
      for (int a = 0; a < N; a++) cov[i][a] = 0;

    start = 1'b1;
    scale_cfg = cfg;
    stall = stall0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || rd_en !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_before_start: busy=%b done=%b rd_en=%b, required all 0", busy, done, rd_en);
    end
    @(posedge clk); #1;
    start = 1'b0;

    uc = 0; cyc = 1; reps = 0; last_e = -1; nstall = 0; fin = 1'b0; done_cyc = -1;
    while (!fin) begin
      e = uc + 1;
      if (e != last_e) reps = 0;
      last_e = e;
      st = 1'b0;
      if (e < U_DONE) begin
        if (mode == 1) st = (e == STALL_E && reps < 3) || (in_drain(e) && reps < 1);
        else if (mode == 2) st = ($urandom_range(0, 3) == 0);
      end
      if (st) begin
        reps++;
        nstall++;
      end
      stall = st;
      scale_cfg = AW'($urandom);
      start = poke ? ((e == U_DONE) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
      @(negedge clk);

      iss  = slot(e, s, b);
      wiss = slot(e - P, ws, wb);
      rda  = '{int'(rd_addr0), int'(rd_addr1), int'(rd_addr2), int'(rd_addr3)};
      wra  = '{int'(wr_addr0), int'(wr_addr1), int'(wr_addr2), int'(wr_addr3)};

      n_checks++;
      if (busy !== (e < U_DONE)) begin
        n_errors++;
        $display("FAIL busy cyc=%0d: got %b required %b", cyc, busy, e < U_DONE);
      end
      n_checks++;
      if (done !== (e == U_DONE)) begin
        n_errors++;
        $display("FAIL done cyc=%0d: got %b required %b", cyc, done, e == U_DONE);
      end
      n_checks++;
      if (rd_en !== (iss && !st)) begin
        n_errors++;
        $display("FAIL rd_en cyc=%0d: got %b required %b", cyc, rd_en, iss && !st);
      end
      n_checks++;
      if (wr_en !== (wiss && !st)) begin
        n_errors++;
        $display("FAIL wr_en cyc=%0d: got %b required %b", cyc, wr_en, wiss && !st);
      end
      if (e < U_DONE) begin
        n_checks++;
        if (int'(stage) !== (e - 1) / (NB + P)) begin
          n_errors++;
          $display("FAIL stage cyc=%0d: got %0d required %0d", cyc, stage, (e - 1) / (NB + P));
        end
      end
      if (iss) begin
        for (int m = 0; m < 4; m++) begin
          n_checks++;
          if (rda[m] !== ref_addr(s, b, m)) begin
            n_errors++;
            $display("FAIL rd_addr%0d s=%0d b=%0d: got %0d required %0d", m, s, b, rda[m], ref_addr(s, b, m));
          end
        end
        n_checks++;
        if (int'(tw_idx) !== ref_tw(s, b)) begin
          n_errors++;
          $display("FAIL tw_idx s=%0d b=%0d: got %0d required %0d", s, b, tw_idx, ref_tw(s, b));
        end
        n_checks++;
        if (int'(scaling) !== int'((cfg >> (2 * s)) & 3)) begin
          n_errors++;
          $display("FAIL scaling s=%0d: got %0d required %0d", s, scaling, (cfg >> (2 * s)) & 3);
        end
        if (spot && b == 5) begin
          for (int m = 0; m < 4; m++) begin
            n_checks++;
            if (rda[m] !== tab[s][m]) begin
              n_errors++;
              $display("FAIL spot_rd%0d s=%0d: got %0d required %0d", m, s, rda[m], tab[s][m]);
            end
          end
          n_checks++;
          if (int'(tw_idx) !== tabtw[s]) begin
            n_errors++;
            $display("FAIL spot_tw s=%0d: got %0d required %0d", s, tw_idx, tabtw[s]);
          end
        end
      end
      if (wiss) begin
        for (int m = 0; m < 4; m++) begin
          n_checks++;
          if (wra[m] !== ref_addr(ws, wb, m)) begin
            n_errors++;
            $display("FAIL wr_addr%0d s=%0d b=%0d: got %0d required %0d", m, ws, wb, wra[m], ref_addr(ws, wb, m));
          end
        end
        if (wr_en === 1'b1)
          for (int m = 0; m < 4; m++) cov[ws][wra[m] % N]++;
      end

      if (e == abort_e) begin
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (all_out !== '0) begin
          n_errors++;
          $display("FAIL reset_async: outputs 0x%0h, required 0", all_out);
        end
        @(posedge clk); #1;
        n_checks++;
        if (all_out !== '0) begin
          n_errors++;
          $display("FAIL reset_next_cycle: outputs 0x%0h, required 0", all_out);
        end
        rst_n = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        return;
      end

      if (e == U_DONE) begin
        done_cyc = cyc;
        fin = 1'b1;
      end else if (cyc >= LIMIT) begin
        n_checks++;
        n_errors++;
        $display("FAIL timeout: no done after %0d cycles, required at %0d", cyc, U_DONE + nstall);
        fin = 1'b1;
      end
      if (!st) uc++;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    stall = 1'b0;

    n_checks++;
    if (done_cyc !== U_DONE + nstall) begin
      n_errors++;
      $display("FAIL done_cycle: got %0d required %0d", done_cyc, U_DONE + nstall);
    end
    for (int i = 0; i < LOG4N; i++) begin
      bad = 0;
      for (int a = 0; a < N; a++) if (cov[i][a] != 1) bad++;
      n_checks++;
      if (bad !== 0) begin
        n_errors++;
        $display("FAIL write_cover stage=%0d: %0d addresses not written exactly once, required 0", i, bad);
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    stall = 1'b0;
    scale_cfg = '1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (all_out !== '0) begin
      n_errors++;
      $display("FAIL reset_state: outputs 0x%0h, required 0", all_out);
    end
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (all_out !== '0) begin
      n_errors++;
      $display("FAIL idle_after_reset: outputs 0x%0h, required 0", all_out);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    // stage 1, b = 7
    run_xform(0, AW'($urandom), 1'b0, 1'b0, 1 * (NB + P) + 7 + 1, 1'b0);
  endtask

  task automatic test_nominal();
    run_xform(0, 6'b11_01_10, 1'b0, 1'b0, -1, 1'b1);
    @(posedge clk); #1;
    // start and stall high together in IDLE: start is accepted
    run_xform(0, 6'b00_10_01, 1'b0, 1'b1, -1, 1'b0);
  endtask

  task automatic test_stall();
    run_xform(1, AW'($urandom), 1'b0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_xform(0, AW'($urandom), 1'b1, 1'b0, -1, 1'b0);
    run_xform(2, AW'($urandom), 1'b1, 1'b0, -1, 1'b0);
    run_xform(0, AW'($urandom), 1'b0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_random();
    repeat (4) begin
      run_xform(2, AW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    stall     = 1'b0;
    scale_cfg = '0;
    test_reset();
    test_reset_mid_run();
    test_nominal();
    test_stall();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
